// File: rtl/regfile_wb_queue_if.sv
// Writeback bundle between the ALU/load paths, the register file write port
// and the decode bypass lookup. The queue is the slave side.
interface regfile_wb_queue_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 3
);
  logic              flush;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] lookup_addr;
  logic              lookup_hit;
  logic [DATA_W-1:0] lookup_data;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  flush, mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data, lookup_addr,
    output mem_ready, alu_ready, rf_write, rf_waddr, rf_wdata, lookup_hit, lookup_data, count
  );

  modport master (
    output flush, mem_valid, mem_addr, mem_data, alu_valid, alu_addr, alu_data, lookup_addr,
    input  mem_ready, alu_ready, rf_write, rf_waddr, rf_wdata, lookup_hit, lookup_data, count
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// In-order writeback queue feeding the MIPS32 register file write port,
// with a youngest-match bypass lookup over the pending entries.
module regfile_wb_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  regfile_wb_queue_if.slave  io_wb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ALMOST = CNT_W'(DEPTH - 1);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_mem_nz;
  logic              w_alu_nz;
  logic              w_mem_ready;
  logic              w_alu_ready;
  logic              w_mem_push;
  logic              w_alu_push;
  logic              w_pop;
  logic [PTR_W-1:0]  w_alu_wptr;
  logic [PTR_W-1:0]  w_wr_next;
  logic [PTR_W-1:0]  w_idx;
  logic              w_hit;
  logic [DATA_W-1:0] w_hit_data;

  assign w_mem_nz    = (io_wb.mem_addr != '0);
  assign w_alu_nz    = (io_wb.alu_addr != '0);
  assign w_mem_ready = (r_count < FULL);
  // A real load write claims a slot first, so the ALU needs two free slots.
  assign w_alu_ready = (io_wb.mem_valid && w_mem_nz) ? (r_count < ALMOST) : (r_count < FULL);
  assign w_mem_push  = io_wb.mem_valid && w_mem_ready && w_mem_nz;
  assign w_alu_push  = io_wb.alu_valid && w_alu_ready && w_alu_nz;
  assign w_pop       = (r_count != '0);
  assign w_alu_wptr  = r_wr_ptr + PTR_W'(w_mem_push);
  assign w_wr_next   = w_alu_wptr + PTR_W'(w_alu_push);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (io_wb.flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_mem_push) begin
        r_addr[r_wr_ptr] <= io_wb.mem_addr;
        r_data[r_wr_ptr] <= io_wb.mem_data;
      end
      if (w_alu_push) begin
        r_addr[w_alu_wptr] <= io_wb.alu_addr;
        r_data[w_alu_wptr] <= io_wb.alu_data;
      end
      r_wr_ptr <= w_wr_next;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_mem_push) + CNT_W'(w_alu_push) - CNT_W'(w_pop);
    end
  end

  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    w_idx      = '0;
    w_hit      = 1'b0;
    w_hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < r_count) && (io_wb.lookup_addr != '0) &&
          (r_addr[w_idx] == io_wb.lookup_addr)) begin
        w_hit      = 1'b1;
        w_hit_data = r_data[w_idx];
      end
    end
  end

  assign io_wb.mem_ready   = w_mem_ready;
  assign io_wb.alu_ready   = w_alu_ready;
  assign io_wb.rf_write    = w_pop;
  assign io_wb.rf_waddr    = w_pop ? r_addr[r_rd_ptr] : '0;
  assign io_wb.rf_wdata    = w_pop ? r_data[r_rd_ptr] : '0;
  assign io_wb.lookup_hit  = w_hit;
  assign io_wb.lookup_data = w_hit_data;
  assign io_wb.count       = r_count;
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboard bench: the driver keeps a queue-level model of pending writes,
// the monitor checks every register file write against the expected stream.
module tb_regfile_wb_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  ent_t mq[$];
  ent_t sb[$];
  ent_t mon_e;

  regfile_wb_queue_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(3)) bus ();

  regfile_wb_queue #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_wb   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.rf_write === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write actual addr=%0d data=%h expected no write", bus.rf_waddr, bus.rf_wdata);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_addr", 32'(bus.rf_waddr), 32'(mon_e.a));
        chk("wr_data", bus.rf_wdata, mon_e.d);
      end
    end
  end

  task automatic drive(input bit mv, input logic [4:0] ma, input logic [31:0] md,
                       input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit fl, input logic [4:0] la);
    bus.mem_valid   = mv;
    bus.mem_addr    = ma;
    bus.mem_data    = md;
    bus.alu_valid   = av;
    bus.alu_addr    = aa;
    bus.alu_data    = ad;
    bus.flush       = fl;
    bus.lookup_addr = la;
  endtask

  // Called just after a rising edge; returns on the next rising edge.
  task automatic cycle(input bit mv, input logic [4:0] ma, input logic [31:0] md,
                       input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit fl, input logic [4:0] la);
    int          n;
    bit          mr, ar, hit;
    logic [31:0] hd;
    ent_t        e;
    #1;
    drive(mv, ma, md, av, aa, ad, fl, la);
    n  = mq.size();
    mr = (n < DEPTH);
    ar = (mv && ma != 0) ? (n < DEPTH - 1) : (n < DEPTH);
    hit = 1'b0;
    hd  = '0;
    for (int i = 0; i < n; i++)
      if (la != 0 && mq[i].a == la) begin
        hit = 1'b1;
        hd  = mq[i].d;
      end
    @(negedge clk);
    chk("count", 32'(bus.count), 32'(n));
    chk("mem_ready", 32'(bus.mem_ready), 32'(mr));
    chk("alu_ready", 32'(bus.alu_ready), 32'(ar));
    chk("rf_write", 32'(bus.rf_write), 32'(n != 0));
    chk("lookup_hit", 32'(bus.lookup_hit), 32'(hit));
    chk("lookup_data", bus.lookup_data, hd);
    @(posedge clk);
    if (fl) begin
      for (int i = 1; i < n; i++) if (sb.size() > 0) sb.delete(sb.size() - 1);
      mq.delete();
    end else begin
      if (n > 0) mq.delete(0);
      if (mv && mr && ma != 0) begin
        e.a = ma; e.d = md;
        mq.push_back(e); sb.push_back(e);
      end
      if (av && ar && aa != 0) begin
        e.a = aa; e.d = ad;
        mq.push_back(e); sb.push_back(e);
      end
    end
  endtask

  task automatic idle(input logic [4:0] la);
    cycle(0, 0, 0, 0, 0, 0, 0, la);
  endtask

  // Asserts reset away from the edge; every pending entry is lost.
  task automatic reset_mid(input logic [4:0] la);
    #1;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, la);
    for (int i = 0; i < mq.size(); i++) if (sb.size() > 0) sb.delete(sb.size() - 1);
    mq.delete();
    #1;
    chk("rst_rf_write", 32'(bus.rf_write), 0);
    chk("rst_rf_waddr", 32'(bus.rf_waddr), 0);
    chk("rst_rf_wdata", bus.rf_wdata, 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_lookup_hit", 32'(bus.lookup_hit), 0);
    chk("rst_lookup_data", bus.lookup_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    reset_mid(5'd3);

    // single ALU write
    cycle(0, 0, 0, 1, 5'd2, 32'd128, 0, 5'd2);
    idle(5'd2);
    idle(5'd2);

    // same-cycle mem and alu to one register: youngest wins the bypass
    cycle(1, 5'd3, 32'hAAAA, 1, 5'd3, 32'h5555, 0, 5'd3);
    idle(5'd3);
    idle(5'd3);
    idle(5'd3);

    // $zero writes are accepted and dropped
    cycle(0, 0, 0, 1, 5'd0, 32'd7, 0, 5'd0);
    idle(5'd0);

    // backpressure near full
    cycle(1, 5'd4, 32'h44, 1, 5'd5, 32'h55, 0, 5'd5);
    cycle(1, 5'd6, 32'h66, 1, 5'd7, 32'h77, 0, 5'd6);
    cycle(1, 5'd8, 32'h88, 1, 5'd9, 32'h99, 0, 5'd9);
    repeat (4) idle(5'd8);

    // flush with two entries and a same-cycle push
    cycle(1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0, 0, 5'd10);
    cycle(0, 0, 0, 1, 5'd12, 32'hC0, 1, 5'd11);
    idle(5'd12);
    idle(5'd11);

    // reset with three entries pending
    cycle(1, 5'd13, 32'hD0, 1, 5'd14, 32'hE0, 0, 5'd13);
    cycle(1, 5'd15, 32'hF0, 1, 5'd16, 32'h100, 0, 5'd15);
    reset_mid(5'd15);
    repeat (3) idle(5'd15);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0) reset_mid(5'($urandom_range(0, 7)));
      else cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 19) == 0, 5'($urandom_range(0, 7)));
    end

    repeat (6) idle(5'd0);
    chk("scoreboard_drained", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
